// File: rtl/cache_line_state_array.sv
// Valid/dirty state for 128 cache lines: one-hot write port, indexed read, flush sequencer.
// Optional CACHE_DIRTY_COUNT_EN adds a registered population count of dirty lines.

module cache_line_state_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] op,
  input  logic       clr,
  output logic       valid,
  output logic       dirty
);
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_DIRTY = 2'b10;
  localparam logic [1:0] OP_INV   = 2'b11;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dirty <= 1'b0;
    end else if (we) begin
      case (op)
        OP_FILL: begin
          valid <= 1'b1;
          dirty <= 1'b0;
        end
        OP_DIRTY: if (valid) dirty <= 1'b1;
        OP_INV: begin
          valid <= 1'b0;
          dirty <= 1'b0;
        end
        default: ;
      endcase
    end else if (clr) begin
      // write-back accepted: line stays valid, becomes clean
      dirty <= 1'b0;
    end
  end
endmodule

module cache_line_state_array #(
  parameter int LINES = 128,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LINES-1:0] sel,
  input  logic             wr_en,
  input  logic [1:0]       op,
  output logic             wr_stall,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done,
  output logic             wb_req,
  output logic [IDX_W-1:0] wb_idx,
  input  logic             wb_ack,
  output logic [IDX_W:0]   dirty_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e           state;
  logic [IDX_W-1:0] ptr;
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic             wr_ok;
  logic             wb_fire;

  assign wr_ok    = wr_en & ~flush_busy;
  assign wr_stall = flush_busy;
  assign wb_req   = flush_busy & dirty[ptr];
  assign wb_idx   = ptr;
  assign wb_fire  = wb_req & wb_ack;
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];

  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    cache_line_state_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok & sel[gi]),
      .op    (op),
      .clr   (wb_fire & (ptr == IDX_W'(gi))),
      .valid (valid[gi]),
      .dirty (dirty[gi])
    );
  end

  // ptr wraps to 0 after the last line, so wb_idx idles at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_start) begin
            state      <= SCAN;
            ptr        <= '0;
            flush_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (!dirty[ptr] || wb_ack) begin
            ptr <= ptr + 1'b1;
            if (ptr == IDX_W'(LINES - 1)) begin
              state      <= DONE;
              flush_busy <= 1'b0;
              flush_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_DIRTY_COUNT_EN
  logic [IDX_W:0] dirty_pop;

  always_comb begin
    dirty_pop = '0;
    for (int i = 0; i < LINES; i++) dirty_pop = dirty_pop + {{IDX_W{1'b0}}, dirty[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) dirty_count <= '0;
    else     dirty_count <= dirty_pop;
  end
`else
  assign dirty_count = '0;
`endif
endmodule

// File: tb/tb_cache_line_state_array.sv
// Randomized + directed bench for cache_line_state_array against a line-level behavioural model.
module tb_cache_line_state_array;
  localparam int LINES = 128;
  localparam int IDX_W = 7;

  logic             clk, rst, wr_en, flush_start, wb_ack;
  logic [LINES-1:0] sel;
  logic [1:0]       op;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_stall, rd_valid, rd_dirty, flush_busy, flush_done, wb_req;
  logic [IDX_W-1:0] wb_idx;
  logic [IDX_W:0]   dirty_count;

  cache_line_state_array #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .op(op), .wr_stall(wr_stall),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_req(wb_req), .wb_idx(wb_idx), .wb_ack(wb_ack), .dirty_count(dirty_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-line flags plus "flushing at line p" / "done pulse" flags.
  bit mv[LINES];
  bit md[LINES];
  bit mflush, mdone;
  int mptr, mcnt, pc;
  bit start_ok, new_done;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin mv[i] = 0; md[i] = 0; end
      mflush = 0; mdone = 0; mptr = 0; mcnt = 0;
    end else begin
      pc = 0;
      for (int i = 0; i < LINES; i++) pc += int'(md[i]);
      start_ok = !mflush && !mdone && flush_start;
      new_done = 0;
      if (!mflush && wr_en) begin
        for (int i = 0; i < LINES; i++) if (sel[i]) begin
          case (op)
            2'b01: begin mv[i] = 1; md[i] = 0; end
            2'b10: if (mv[i]) md[i] = 1;
            2'b11: begin mv[i] = 0; md[i] = 0; end
            default: ;
          endcase
        end
      end
      if (mflush) begin
        if (!md[mptr] || wb_ack) begin
          md[mptr] = 0;
          if (mptr == LINES - 1) begin mflush = 0; new_done = 1; mptr = 0; end
          else mptr++;
        end
      end else if (start_ok) begin
        mflush = 1; mptr = 0;
      end
      mdone = new_done;
      mcnt = pc;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_valid", rd_valid, mv[rd_idx]);
      chk("rd_dirty", rd_dirty, md[rd_idx]);
      chk("flush_busy", flush_busy, mflush);
      chk("wr_stall", wr_stall, mflush);
      chk("flush_done", flush_done, mdone);
      chk("wb_req", wb_req, mflush && md[mptr]);
      if (mflush && md[mptr]) chk("wb_idx", wb_idx, mptr);
`ifdef CACHE_DIRTY_COUNT_EN
      chk("dirty_count", dirty_count, mcnt);
`else
      chk("dirty_count", dirty_count, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic wr(input logic [1:0] o, input int a, input int b, input int c);
    sel = '0;
    if (a >= 0) sel[a] = 1'b1;
    if (b >= 0) sel[b] = 1'b1;
    if (c >= 0) sel[c] = 1'b1;
    op = o; wr_en = 1; tick(); wr_en = 0; sel = '0; op = 2'b00;
  endtask

  task automatic rd(input int idx, output logic v, output logic d);
    rd_idx = IDX_W'(idx); #1; v = rd_valid; d = rd_dirty;
  endtask

  int req_cyc[LINES];
  int done_n, done_cnt, busy_n, req_total;
  logic stall_at_fill;

  // Line slow_idx is acked on its slow_cyc-th request cycle; all others immediately.
  task automatic run_flush(input int slow_idx, input int slow_cyc, input int fill_at, input int fill_line);
    for (int i = 0; i < LINES; i++) req_cyc[i] = 0;
    done_n = -1; done_cnt = 0; busy_n = 0; req_total = 0; stall_at_fill = 0;
    flush_start = 1; tick(); flush_start = 0;
    for (int n = 1; n <= 400; n++) begin
      wr_en = 0; sel = '0;
      if (n == fill_at) begin wr_en = 1; op = 2'b01; sel[fill_line] = 1'b1; stall_at_fill = wr_stall; end
      if (flush_busy) busy_n++;
      if (flush_done) begin done_cnt++; if (done_n < 0) done_n = n; end
      wb_ack = 0;
      if (wb_req) begin
        req_cyc[wb_idx]++; req_total++;
        wb_ack = (int'(wb_idx) != slow_idx) || (req_cyc[wb_idx] >= slow_cyc);
      end
      tick();
      if (done_n > 0 && n > done_n + 3) break;
    end
    wr_en = 0; sel = '0; wb_ack = 0; op = 2'b00;
    if (done_n < 0) chk("flush_timeout", 0, 1);
  endtask

  logic v, d;
  bit   seen;
  int   nb;

  initial begin
    rst = 1; wr_en = 0; sel = '0; op = 2'b00; flush_start = 0; wb_ack = 0; rd_idx = '0;
    tick();
    cmp_en = 1;
    tick();
    rst = 0;

    // reset state
    rd(0, v, d);   chk("rst_v0", v, 0);   chk("rst_d0", d, 0);
    rd(64, v, d);  chk("rst_v64", v, 0);  chk("rst_d64", d, 0);
    rd(127, v, d); chk("rst_v127", v, 0); chk("rst_d127", d, 0);
    chk("rst_wb_req", wb_req, 0); chk("rst_busy", flush_busy, 0); chk("rst_wb_idx", wb_idx, 0);

    // fill + mark-dirty, mark-dirty on invalid line
    wr(2'b01, 5, -1, -1);
    wr(2'b10, 5, -1, -1);
    wr(2'b10, 6, -1, -1);
    rd(5, v, d); chk("l5_v", v, 1); chk("l5_d", d, 1);
    rd(6, v, d); chk("l6_v", v, 0); chk("l6_d", d, 0);

    // multi-select fill, then invalidate one
    wr(2'b01, 3, 70, 127);
    rd(70, v, d); chk("l70_fill", v, 1);
    wr(2'b11, 70, -1, -1);
    rd(70, v, d); chk("l70_v", v, 0); chk("l70_d", d, 0);
    tick();
    rd(3, v, d);   chk("l3_v", v, 1);   chk("l3_d", d, 0);
    rd(127, v, d); chk("l127_v", v, 1); chk("l127_d", d, 0);

    // flush with lines 10 and 100 dirty; line 10 acked after 3 wait cycles
    do_reset();
    wr(2'b01, 10, 100, -1);
    wr(2'b10, 10, 100, -1);
    run_flush(10, 4, -1, 0);
    chk("f_req10", req_cyc[10], 4);
    chk("f_req100", req_cyc[100], 1);
    chk("f_req_total", req_total, 5);
    chk("f_done_n", done_n, 132);
    chk("f_done_cnt", done_cnt, 1);
    chk("f_busy_n", busy_n, 131);
    rd(10, v, d);  chk("f_l10_v", v, 1);  chk("f_l10_d", d, 0);
    rd(100, v, d); chk("f_l100_v", v, 1); chk("f_l100_d", d, 0);

    // clean flush with a fill attempted mid-flush
    do_reset();
    run_flush(-1, 0, 50, 20);
    chk("c_busy_n", busy_n, 128);
    chk("c_done_n", done_n, 129);
    chk("c_done_cnt", done_cnt, 1);
    chk("c_req_total", req_total, 0);
    chk("c_stall", stall_at_fill, 1);
    rd(20, v, d); chk("c_l20_v", v, 0);

    // reset while a write-back is pending on line 40
    do_reset();
    wr(2'b01, 40, -1, -1);
    wr(2'b10, 40, -1, -1);
    flush_start = 1; tick(); flush_start = 0;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (wb_req && wb_idx == 7'd40) seen = 1; else tick();
    end
    chk("r_req40_seen", seen, 1);
    rst = 1; tick(); rst = 0;
    chk("r_wb_req", wb_req, 0); chk("r_busy", flush_busy, 0);
    nb = 0;
    for (int n = 0; n < 140; n++) begin if (flush_done || wb_req) nb++; tick(); end
    chk("r_no_done", nb, 0);
    rd(40, v, d); chk("r_l40_v", v, 0); chk("r_l40_d", d, 0);

`ifdef CACHE_DIRTY_COUNT_EN
    do_reset();
    wr(2'b01, 1, 2, 3);
    wr(2'b10, 1, 2, 3);
    chk("dc_lag", dirty_count, 0);
    tick();
    chk("dc_three", dirty_count, 3);
    run_flush(-1, 0, -1, 0);
    chk("dc_after_flush", dirty_count, 0);
`endif

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 499) == 0);
      wr_en       = $urandom_range(0, 1);
      op          = 2'($urandom_range(0, 3));
      flush_start = ($urandom_range(0, 199) == 0);
      wb_ack      = ($urandom_range(0, 2) == 0);
      rd_idx      = IDX_W'($urandom_range(0, LINES - 1));
      sel = '0;
      for (int k = $urandom_range(0, 3); k > 0; k--) sel[$urandom_range(0, LINES - 1)] = 1'b1;
      tick();
    end
    rst = 0; wr_en = 0; flush_start = 0; wb_ack = 0; sel = '0;
    tick();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_line_state_array.md
Name: cache_line_state_array

Overview:
- 128-entry valid/dirty state store for the cache data array.
- Sits directly downstream of the 7-to-128 tag/index decoder and consumes its one-hot select vector to update per-line state.
- Provides an indexed read port for hit/miss logic.
- Contains a flush sequencer that walks all lines and issues write-back requests for dirty lines over a req/ack handshake.

Parameters:
- LINES, 128, number of cache lines (width of sel vector).
- IDX_W, 7, index width; LINES == 2**IDX_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  LINES  one-hot line select from decoder. All-zero = no line selected.
- wr_en  in  1  apply op to selected lines this cycle.
- op  in  2  00 nop, 01 fill, 10 mark-dirty, 11 invalidate.
- wr_stall  out  1  high while flush busy; writes dropped.
- rd_idx  in  IDX_W  read index.
- rd_valid  out  1  valid bit of line rd_idx.
- rd_dirty  out  1  dirty bit of line rd_idx.
- flush_start  in  1  request a full flush.
- flush_busy  out  1  flush sequencer scanning.
- flush_done  out  1  one-cycle pulse at end of flush.
- wb_req  out  1  write-back request for line wb_idx.
- wb_idx  out  IDX_W  line being written back.
- wb_ack  in  1  write-back accepted.
- dirty_count  out  IDX_W+1  number of dirty lines (optional feature).

Behaviour:
- Reset (synchronous, active-high):
  - All valid and dirty bits cleared.
  - FSM to IDLE; scan pointer 0.
  - flush_busy, flush_done, wb_req = 0; wb_idx = 0; dirty_count = 0.
  - rst has priority over every other input, including mid-flush: the flush aborts with no flush_done and no further wb_req.
- Write port, when wr_en=1 and flush_busy=0, for every i with sel[i]=1 (multiple bits allowed, all updated identically):
  - fill: valid=1, dirty=0.
  - mark-dirty: dirty=1 only if valid=1; otherwise no change.
  - invalidate: valid=0, dirty=0.
  - nop: no change.
- sel=0 or wr_en=0 leaves state unchanged.
- Write during flush_busy=1 is ignored. wr_stall = flush_busy (combinational) so upstream holds and retries.
- Read port is combinational from the array. A write at edge t is visible on rd_valid/rd_dirty after edge t; there is no write-to-read bypass.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: flush_start=1 -> SCAN, ptr=0. While in SCAN or DONE, flush_start is ignored.
  - SCAN:
    - flush_busy=1; wb_idx=ptr; wb_req = dirty[ptr] (combinational).
    - If dirty[ptr]=0: advance.
    - If dirty[ptr]=1: hold ptr until wb_ack=1. On that edge clear dirty[ptr] (valid unchanged), then advance.
    - Advance: if ptr==LINES-1 -> DONE, else ptr+1.
    - wb_ack while wb_req=0 is ignored.
  - DONE: flush_done=1, flush_busy=0, for one cycle -> IDLE. A write may be accepted in DONE.
- Clean array timing: flush_start sampled at edge 0 -> flush_busy high for cycles 1..128 -> flush_done in cycle 129.
- Each dirty line adds exactly the number of cycles wb_ack is held low.
- wb_req stays high until acked. wb_idx is stable while wb_req is high.

Optional Feature:
- Macro: CACHE_DIRTY_COUNT_EN.
- Defined: dirty_count is a register equal to the population count of the dirty bits as of the previous edge, so it lags the array by one cycle. Range 0..128; reset 0.
- Undefined: dirty_count tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then read indices 0, 64, 127 -> rd_valid=0, rd_dirty=0, wb_req=0, flush_busy=0.
- Fill with sel bit 5; next cycle mark-dirty with sel bit 5; then read rd_idx=5 -> valid=1, dirty=1. Mark-dirty on invalid line 6 -> rd_dirty=0 at idx 6.
- Fill with sel=bits 3|70|127 in one cycle -> all three valid. Then invalidate bit 70 -> idx 70 reads valid=0, dirty=0, and idx 3/127 unchanged.
- Lines 10 and 100 dirty; flush_start; ack line 10 after 3 cycles and line 100 immediately:
  - wb_req/wb_idx=10 held for 4 cycles, then wb_idx=100 for 1 cycle.
  - flush_done 1+128+3 cycles after start.
  - Both lines afterwards valid=1, dirty=0.
- Clean array flush -> 128 busy cycles, done pulse once, wb_req never high. fill issued mid-flush -> wr_stall=1 and the line stays invalid.
- rst asserted while wb_req high at idx 40 -> next cycle wb_req=0, busy=0, no flush_done, all lines invalid.
- With CACHE_DIRTY_COUNT_EN, 3 dirty lines -> dirty_count=3 one cycle later, and 0 after flush.
